// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared widths, ALU op encodings and multiplier FSM states for the execute stage
package exec_pkg;

    localparam int DATA_W    = 19;
    localparam int PC_W      = 15;
    localparam int RA_W      = 5;
    localparam int SHAMT_W   = 5;
    localparam int MUL_STEPS = 19;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SLT = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - decode-to-execute operand/control bundle and EX/MEM outputs
// master: decode side drives the E-side controls/operands and observes redirect, stall and M outputs.
// slave : the execute stage consumes the E-side signals and drives redirect, stall and M outputs.
interface execute_stage_if;
    import exec_pkg::*;

    logic              RegWriteE;
    logic              MemWriteE;
    logic              JumpE;
    logic              BranchE;
    logic              ALUSrcE;
    logic [1:0]        ResultSrcE;
    logic [2:0]        ALUControlE;
    logic [DATA_W-1:0] RD1E;
    logic [DATA_W-1:0] RD2E;
    logic [DATA_W-1:0] ImmExtE;
    logic [PC_W-1:0]   PCE;
    logic [RA_W-1:0]   RDE;

    logic              PCSrcE;
    logic [PC_W-1:0]   PCTargetE;
    logic              StallE;

    logic              RegWriteM;
    logic              MemWriteM;
    logic [1:0]        ResultSrcM;
    logic [DATA_W-1:0] ALUResultM;
    logic [DATA_W-1:0] WriteDataM;
    logic [RA_W-1:0]   RdM;
    logic [PC_W-1:0]   PCPlus1M;

    modport master (
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, RDE,
        input  PCSrcE, PCTargetE, StallE,
               RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus1M
    );

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, RDE,
        output PCSrcE, PCTargetE, StallE,
               RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus1M
    );

endinterface

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational ALU with zero flag (macro EXECUTE_MUL_EN selects op 111 meaning)
// Ports: src_a, src_b operands; alu_control op; result; zero = (result == 0).
// Without EXECUTE_MUL_EN op 111 is a logical shift right; with it the product comes from
// the multiplier in execute_stage and this unit returns 0 for op 111.
module exec_alu
    import exec_pkg::*;
(
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  alu_op_t           alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic [SHAMT_W-1:0] shamt;
    logic               shift_out;

    assign shamt     = src_b[SHAMT_W-1:0];
    // Shift amounts past the datapath width clear the result.
    assign shift_out = (shamt >= SHAMT_W'(DATA_W));

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_XOR: result = src_a ^ src_b;
            ALU_SLL: result = shift_out ? '0 : (src_a << shamt);
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef EXECUTE_MUL_EN
            ALU_MUL: result = '0;
`else
            ALU_MUL: result = shift_out ? '0 : (src_a >> shamt);
`endif
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: operand select, ALU, branch resolve, EX/MEM register (macro EXECUTE_MUL_EN)
// Ports: clk; reset (async, active-low); bus (execute_stage_if.slave) carrying E-side
// controls/operands in and PCSrcE/PCTargetE/StallE plus registered M outputs back.
// EXECUTE_MUL_EN adds a 19-step shift-add multiplier for op 111 that stalls upstream.
module execute_stage
    import exec_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave bus
);

    alu_op_t           alu_op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] ex_result;
    logic              ex_zero;
    logic              stall_e;

    assign alu_op = alu_op_t'(bus.ALUControlE);
    assign src_a  = bus.RD1E;
    assign src_b  = bus.ALUSrcE ? bus.ImmExtE : bus.RD2E;

    exec_alu u_alu (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_op),
        .result      (alu_result),
        .zero        (alu_zero)
    );

`ifdef EXECUTE_MUL_EN
    mul_state_t        mul_state;
    logic [DATA_W-1:0] mul_mcand;
    logic [DATA_W-1:0] mul_mplier;
    logic [DATA_W-1:0] mul_acc;
    logic [4:0]        mul_count;

    // Reset gates the stall so an aborted multiply never holds upstream during reset.
    assign stall_e = reset &&
                     (((mul_state == MUL_IDLE) && (alu_op == ALU_MUL)) || (mul_state == MUL_BUSY));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_state  <= MUL_IDLE;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
            mul_count  <= '0;
        end else begin
            case (mul_state)
                MUL_IDLE: begin
                    if (alu_op == ALU_MUL) begin
                        mul_state  <= MUL_BUSY;
                        mul_mcand  <= src_a;
                        mul_mplier <= src_b;
                        mul_acc    <= '0;
                        mul_count  <= '0;
                    end
                end
                MUL_BUSY: begin
                    // One shift-add step per cycle; bits shifted past DATA_W are dropped,
                    // which leaves the low DATA_W bits of the product in mul_acc.
                    if (mul_mplier[0]) begin
                        mul_acc <= mul_acc + mul_mcand;
                    end
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    if (mul_count == 5'(MUL_STEPS - 1)) begin
                        mul_state <= MUL_DONE;
                    end else begin
                        mul_count <= mul_count + 5'd1;
                    end
                end
                MUL_DONE: mul_state <= MUL_IDLE;
                default:  mul_state <= MUL_IDLE;
            endcase
        end
    end

    assign ex_result = (mul_state == MUL_DONE) ? mul_acc : alu_result;
    assign ex_zero   = (mul_state == MUL_DONE) ? (mul_acc == '0) : alu_zero;
`else
    assign stall_e   = 1'b0;
    assign ex_result = alu_result;
    assign ex_zero   = alu_zero;
`endif

    assign bus.StallE    = stall_e;
    assign bus.PCSrcE    = !stall_e && (bus.JumpE || (bus.BranchE && ex_zero));
    assign bus.PCTargetE = stall_e ? '0 : (bus.PCE + bus.ImmExtE[PC_W-1:0]);

    // EX/MEM register: a stalled cycle inserts a bubble so nothing retires twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.RdM        <= '0;
            bus.PCPlus1M   <= '0;
        end else if (stall_e) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.RdM        <= '0;
            bus.PCPlus1M   <= '0;
        end else begin
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.ResultSrcM <= bus.ResultSrcE;
            bus.ALUResultM <= ex_result;
            bus.WriteDataM <= bus.RD2E;
            bus.RdM        <= bus.RDE;
            bus.PCPlus1M   <= bus.PCE + PC_W'(1);
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage (honours EXECUTE_MUL_EN)
module tb_execute_stage;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    execute_stage_if bus ();

    execute_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.RegWriteE   = 1'b0;
        bus.MemWriteE   = 1'b0;
        bus.JumpE       = 1'b0;
        bus.BranchE     = 1'b0;
        bus.ALUSrcE     = 1'b0;
        bus.ResultSrcE  = 2'd0;
        bus.ALUControlE = 3'd0;
        bus.RD1E        = '0;
        bus.RD2E        = '0;
        bus.ImmExtE     = '0;
        bus.PCE         = '0;
        bus.RDE         = '0;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [18:0] a, input logic [18:0] b);
        clear_inputs();
        bus.ALUControlE = op;
        bus.RD1E        = a;
        bus.RD2E        = b;
    endtask

    // Advance to 1 ns after the next rising edge: inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_case(input string tag, input logic [2:0] op, input logic [18:0] a,
                            input logic [18:0] b, input logic [18:0] exp);
        set_op(op, a, b);
        step();
        check_eq(tag, bus.ALUResultM, exp);
    endtask

`ifdef EXECUTE_MUL_EN
    task automatic run_mul(input string tag, input logic [18:0] a, input logic [18:0] b,
                           input logic [4:0] rd, input logic [18:0] exp);
        int stall_cnt;
        int bubble_bad;
        set_op(3'b111, a, b);
        bus.RegWriteE = 1'b1;
        bus.RDE       = rd;
        #1;
        stall_cnt  = 0;
        bubble_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.StallE) break;
            stall_cnt++;
            step();
            if (bus.RegWriteM !== 1'b0) bubble_bad++;
        end
        check_eq({tag, "_stall_cycles"}, stall_cnt, 20);
        check_eq({tag, "_bubbles"}, bubble_bad, 0);
        step();
        check_eq({tag, "_result"}, bus.ALUResultM, exp);
        check_eq({tag, "_rd"}, bus.RdM, rd);
        check_eq({tag, "_regwrite"}, bus.RegWriteM, 1);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        clear_inputs();
        repeat (2) step();
        check_eq("rst_alu", bus.ALUResultM, 0);
        check_eq("rst_regwrite", bus.RegWriteM, 0);
        check_eq("rst_stall", bus.StallE, 0);

        reset = 1'b1;
        set_op(3'b000, 19'd5, 19'd7);
        bus.RegWriteE = 1'b1;
        bus.RDE       = 5'd4;
        step();
        check_eq("add_5_7", bus.ALUResultM, 12);
        check_eq("add_regwrite", bus.RegWriteM, 1);
        check_eq("add_rd", bus.RdM, 4);
        check_eq("add_wdata", bus.WriteDataM, 7);

        // Asynchronous reset mid-stream clears M outputs without a clock edge.
        #1 reset = 1'b0;
        #1;
        check_eq("async_rst_alu", bus.ALUResultM, 0);
        check_eq("async_rst_rd", bus.RdM, 0);
        check_eq("async_rst_stall", bus.StallE, 0);
        step();
        reset = 1'b1;

        alu_case("sub_3_5",   3'b001, 19'd3, 19'd5, 19'h7FFFE);
        alu_case("slt_neg",   3'b110, 19'h40000, 19'd1, 19'd1);
        alu_case("slt_pos",   3'b110, 19'd1, 19'h40000, 19'd0);
        alu_case("add_wrap",  3'b000, 19'h7FFFF, 19'd1, 19'd0);
        alu_case("and",       3'b010, 19'h0F0F0, 19'h0FF00, 19'h0F000);
        alu_case("or",        3'b011, 19'h0F0F0, 19'h0FF00, 19'h0FFF0);
        alu_case("xor",       3'b100, 19'h0F0F0, 19'h0FF00, 19'h00FF0);
        alu_case("sll_18",    3'b101, 19'd1, 19'd18, 19'h40000);
        alu_case("sll_19",    3'b101, 19'd1, 19'd19, 19'd0);

        set_op(3'b101, 19'd5, 19'd0);
        bus.ALUSrcE = 1'b1;
        bus.ImmExtE = 19'd3;
        step();
        check_eq("sll_imm", bus.ALUResultM, 19'h28);

        set_op(3'b000, 19'd1, 19'h01234);
        bus.MemWriteE  = 1'b1;
        bus.ResultSrcE = 2'd2;
        step();
        check_eq("store_memwrite", bus.MemWriteM, 1);
        check_eq("store_wdata", bus.WriteDataM, 19'h01234);
        check_eq("store_rsrc", bus.ResultSrcM, 2);

        set_op(3'b001, 19'd9, 19'd9);
        bus.BranchE = 1'b1;
        bus.PCE     = 15'h0010;
        bus.ImmExtE = 19'h00004;
        #1;
        check_eq("beq_taken", bus.PCSrcE, 1);
        check_eq("beq_target", bus.PCTargetE, 15'h0014);
        bus.RD2E = 19'd8;
        #1;
        check_eq("beq_not_taken", bus.PCSrcE, 0);
        step();
        check_eq("beq_pcplus1", bus.PCPlus1M, 15'h0011);

        set_op(3'b000, 19'd0, 19'd0);
        bus.JumpE   = 1'b1;
        bus.PCE     = 15'h7FFF;
        bus.ImmExtE = 19'h00004;
        #1;
        check_eq("jump_taken", bus.PCSrcE, 1);
        check_eq("jump_target_wrap", bus.PCTargetE, 15'h0003);
        step();
        check_eq("pcplus1_wrap", bus.PCPlus1M, 0);

`ifdef EXECUTE_MUL_EN
        run_mul("mul_123_45", 19'd123, 19'd45, 5'd3, 19'd5535);
        run_mul("mul_wrap", 19'h7FFFF, 19'd2, 5'd6, 19'h7FFFE);
        run_mul("mul_b2b", 19'd300, 19'd7, 5'd9, 19'd2100);

        // Abort after the issue cycle plus 10 BUSY cycles.
        set_op(3'b111, 19'd11, 19'd13);
        repeat (11) step();
        check_eq("abort_busy_stall", bus.StallE, 1);
        reset = 1'b0;
        #1;
        check_eq("abort_stall", bus.StallE, 0);
        set_op(3'b000, 19'd2, 19'd3);
        #2 reset = 1'b1;
        #1;
        check_eq("after_abort_stall", bus.StallE, 0);
        step();
        check_eq("after_abort_add", bus.ALUResultM, 5);
        run_mul("mul_after_abort", 19'd123, 19'd45, 5'd3, 19'd5535);
`else
        set_op(3'b111, 19'h00100, 19'd4);
        #1;
        check_eq("srl_stall", bus.StallE, 0);
        step();
        check_eq("srl_result", bus.ALUResultM, 19'h00010);
        check_eq("srl_stall_after", bus.StallE, 0);
        alu_case("srl_19", 3'b111, 19'h7FFFF, 19'd19, 19'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
